// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war computer opponent.
package tow_pkg;

  // Width of the pseudo-random press generator and its feedback taps.
  localparam int LFSR_WIDTH  = 10;
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

  // Press sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } cpu_state_t;

endpackage : tow_pkg

// File: rtl/cpu_player_lfsr10.sv
// 10-bit Fibonacci LFSR in XNOR form: resets to zero, never reaches all-ones,
// period 1023. Shifts only on cycles where Adv is high.
module lfsr10
  import tow_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Adv,
  output logic [LFSR_WIDTH-1:0] Q
);

  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [LFSR_WIDTH-1:0] lfsr_d;
  logic                  fb;

  // Next value: shift in the XNOR of the two taps when advancing.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
    lfsr_d = lfsr_q;
    fb     = ~(lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]);
    if (Adv) begin
      lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], fb};
    end
  end

  // Shift register with asynchronous clear to the all-zero seed.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lfsr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      lfsr_q <= lfsr_d;
    end
  end

  assign Q = lfsr_q;

endmodule : lfsr10

// File: rtl/cpu_player.sv
// Computer opponent: emits a pushbutton-like Key level (HOLD_CYCLES high, then
// at least GAP_CYCLES low) when the LFSR falls below the difficulty on a Tick.
module cpu_player
  import tow_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,  // >= 1
  parameter int GAP_CYCLES  = 2   // >= 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Tick,
  input  logic [8:0] Speed,
  output logic       Key,
  output logic       Press,
  output logic       Busy
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  cpu_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   key_q, key_d;
  logic                   press_q, press_d;
  logic [LFSR_WIDTH-1:0]  lfsr;
  logic                   fire;

  lfsr10 u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .Adv   (Tick),
    .Q     (lfsr)
  );

  // Fire decision: compares against the LFSR value before this cycle's shift.
  assign fire = Tick && Enable && (state_q == IDLE) && ({1'b0, Speed} > lfsr);

  // Press sequencer: next state, counter and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = PRESS;
          cnt_d   = HOLD_LOAD;
          press_d = 1'b1;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Key mirrors the state being entered, so it comes straight off a flop.
    key_d = (state_d == PRESS);
  end

  // State, counter and output registers; reset forces everything idle at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      press_q <= press_d;
    end
  end

  assign Key   = key_q;
  assign Press = press_q;
  assign Busy  = (state_q != IDLE);

endmodule : cpu_player

// File: doc/cpu_player.md
# cpu_player

Computer opponent for the tug-of-war game. It produces the same key-press signal that a human player produces on a pushbutton: a level `Key` held for a fixed number of cycles, then released. Its output feeds the same per-player input conditioner as a human key. Press decisions come from a 10-bit LFSR compared against a difficulty value taken from the board switches, and are evaluated once per game tick.

## Interface
- `HOLD_CYCLES`, default 2: cycles `Key` stays high per press; must be at least 1.
- `GAP_CYCLES`, default 2: minimum cycles `Key` stays low after a press; must be at least 1.
- `Clock`  input  1  system clock; all state changes on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset (fixed decision).
- `Enable`  input  1  permits new presses; 0 during game-over or a human-vs-human game.
- `Tick`  input  1  one-cycle game-rate strobe; the only cycle where a fire decision is made.
- `Speed`  input  9  difficulty; 0 means never press, and larger values press more often.
- `Key`  output  1  simulated pushbutton level, driven straight from a register.
- `Press`  output  1  one-cycle strobe in the first cycle of each press, for the score/debug LEDs.
- `Busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- **LFSR**
  - 10-bit Fibonacci register, shifted as `lfsr <= {lfsr[8:0], fb}` with `fb = ~(lfsr[9] ^ lfsr[6])` (XNOR form).
  - Reset value is 0. The period is 1023, and the all-ones state is unreachable.
  - It advances on every cycle with `Tick`=1, whatever the FSM state or `Enable`.
- **Fire condition**
  - fire = `Tick` && `Enable` && (state == IDLE) && ({1'b0, `Speed`} > lfsr).
  - The comparison uses the lfsr value before that cycle's shift.
- **FSM states**
  - IDLE
    - `Key`=0.
    - On fire, load the counter with HOLD_CYCLES-1 and go to PRESS.
  - PRESS
    - `Key`=1.
    - When the counter reaches 0, load it with GAP_CYCLES-1 and go to RELEASE. Otherwise decrement.
  - RELEASE
    - `Key`=0.
    - When the counter reaches 0, go to IDLE. Otherwise decrement.
- **Mid-press events**
  - A press that has started always completes. Dropping `Enable` during PRESS or RELEASE does not shorten it.
  - `Tick` during PRESS or RELEASE shifts the LFSR but never queues a fire.
- **Outputs**
  - `Press` is registered: it is 1 exactly in the first PRESS cycle.
  - `Busy` = (state != IDLE).
- **Counter width**: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).

## Timing
- **Reset**: asserting `Reset` at any time, including mid-press, forces the following at once, without waiting for a clock:
  - state = IDLE, lfsr = 0, counter = 0
  - `Key`=0, `Press`=0, `Busy`=0
- **Fire at cycle t**:
  - state = PRESS and `Key`=1 over cycles t+1 .. t+HOLD_CYCLES.
  - `Press`=1 at t+1 only.
  - RELEASE over cycles t+HOLD_CYCLES+1 .. t+HOLD_CYCLES+GAP_CYCLES.
  - IDLE at t+HOLD_CYCLES+GAP_CYCLES+1. A `Tick` in that same cycle may fire again.
- **Maximum press rate**: one press per HOLD_CYCLES+GAP_CYCLES+1 cycles. Consecutive presses are always separated by at least GAP_CYCLES cycles of `Key`=0, so the downstream conditioner sees each press as a distinct rising edge.
- **Latency**: one cycle from the fire decision to `Key` rising.

## Structure
- **Package `tow_pkg`**:
  - `LFSR_WIDTH` = 10
  - tap constants (9, 6)
  - `cpu_state_t` enum {IDLE, PRESS, RELEASE}
- **Sub-module `lfsr10`**:
  - ports: `Clock`, `Reset`, `Adv`, `Q[9:0]`
  - holds the shift register and feedback
  - `cpu_player` instantiates it with `Adv` = `Tick`
- The FSM, counter and comparator live in `cpu_player`. All outputs are registered or decoded from state only, with no path from inputs to outputs.

## Test plan
- **Reset and first value**: reset, then Enable=1, Speed=1, one Tick → fires, because lfsr=0 and 1>0. Key=1 for exactly 2 cycles starting the next cycle, Press=1 for 1 cycle, Busy=1 for 4 cycles.
- **Never/always firing**
  - Speed=0, Enable=1, Tick every cycle for 3000 cycles → Key never 1, and lfsr returns to 0 after 1023 Ticks.
  - Speed=511 → a press starts on every IDLE Tick whose lfsr is below 511.
- **Enable gating**
  - Enable=0, Speed=511, 100 Ticks → no Press.
  - Enable dropped in the first PRESS cycle → Key still high for the full 2 cycles, then the full gap.
- **Back-to-back**: Tick every cycle, Speed=511, HOLD=2, GAP=2 → no two Press strobes closer than 5 cycles, and Key low for ≥2 cycles between presses.
- **Async reset mid-press**: assert Reset between clock edges during PRESS → Key=0 and Busy=0 before the next edge. After release, the next Tick uses lfsr=0.
- **Reference model**: run a bit-accurate software model of the LFSR and FSM over 10000 random Tick/Enable/Speed cycles → Key, Press and Busy match the model every cycle.
